// File: rtl/crc8_frame_arbiter_if.sv
// Byte-stream request side and CRC result side of the shared CRC-8 engine.
// Two requesters share in_valid/in_data/in_last/in_ready; bit i (byte i) belongs to requester i.
interface crc8_frame_arbiter_if;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_last;
    logic [1:0]  in_ready;
    logic [7:0]  crc_out;
    logic        crc_id;
    logic        crc_valid;
    logic        frame_err;
    logic        busy;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, crc_out, crc_id, crc_valid, frame_err, busy
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, crc_out, crc_id, crc_valid, frame_err, busy
    );
endinterface

// File: rtl/crc8_frame_arbiter.sv
// Round-robin arbiter in front of one bit-serial reflected CRC-8 engine.
// A grant covers a whole frame; one tagged result (or an abort strobe) per frame.
module crc8_frame_arbiter #(
    parameter logic [7:0]  INIT    = 8'hFF,
    parameter logic [7:0]  POLY    = 8'h8C,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    crc8_frame_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_crc, w_crc_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_to, w_to_nxt;
    logic       r_grant, w_grant_nxt;
    logic       r_is_last, w_is_last_nxt;
    logic [7:0] r_crc_out, w_crc_out_nxt;
    logic       r_crc_id, w_crc_id_nxt;
    logic       r_crc_valid, w_crc_valid_nxt;
    logic       r_frame_err, w_frame_err_nxt;

    logic [7:0] w_byte;
    logic       w_gvalid;
    logic       w_glast;
    logic       w_to_expired;

    assign w_byte       = r_grant ? bus.in_data[15:8] : bus.in_data[7:0];
    assign w_gvalid     = bus.in_valid[r_grant];
    assign w_glast      = bus.in_last[r_grant];
    assign w_to_expired = (TIMEOUT != 0) && (r_to == TO_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_crc       <= INIT;
            r_cnt       <= '0;
            r_to        <= '0;
            r_grant     <= 1'b1;
            r_is_last   <= 1'b0;
            r_crc_out   <= '0;
            r_crc_id    <= 1'b0;
            r_crc_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_crc       <= w_crc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to        <= w_to_nxt;
            r_grant     <= w_grant_nxt;
            r_is_last   <= w_is_last_nxt;
            r_crc_out   <= w_crc_out_nxt;
            r_crc_id    <= w_crc_id_nxt;
            r_crc_valid <= w_crc_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_crc_nxt       = r_crc;
        w_cnt_nxt       = r_cnt;
        w_to_nxt        = r_to;
        w_grant_nxt     = r_grant;
        w_is_last_nxt   = r_is_last;
        w_crc_out_nxt   = r_crc_out;
        w_crc_id_nxt    = r_crc_id;
        w_crc_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        bus.in_ready    = '0;
        case (r_state)
            IDLE: begin
                if (|bus.in_valid) begin
                    // Contention flips the pointer; a lone requester simply wins.
                    w_grant_nxt = (&bus.in_valid) ? ~r_grant : bus.in_valid[1];
                    w_to_nxt    = '0;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = r_grant ? 2'b10 : 2'b01;
                if (w_gvalid) begin
                    w_crc_nxt     = r_crc ^ w_byte;
                    w_is_last_nxt = w_glast;
                    w_cnt_nxt     = '0;
                    w_to_nxt      = '0;
                    w_state_nxt   = SHIFT;
                end else if (w_to_expired) begin
                    w_frame_err_nxt = 1'b1;
                    w_crc_nxt       = INIT;
                    w_to_nxt        = '0;
                    w_state_nxt     = IDLE;
                end else begin
                    w_to_nxt = r_to + 8'd1;
                end
            end
            SHIFT: begin
                w_crc_nxt = {1'b0, r_crc[7:1]} ^ (r_crc[0] ? POLY : '0);
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = r_is_last ? DONE : LOAD;
                end
            end
            DONE: begin
                w_crc_valid_nxt = 1'b1;
                w_crc_out_nxt   = r_crc;
                w_crc_id_nxt    = r_grant;
                w_crc_nxt       = INIT;
                w_state_nxt     = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.crc_out   = r_crc_out;
    assign bus.crc_id    = r_crc_id;
    assign bus.crc_valid = r_crc_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// Scoreboard bench: two instances (INIT=FF and INIT=00) driven by the same byte streams;
// expected results come from a plain CRC-8 reference and are checked by an independent monitor.
module tb_crc8_frame_arbiter;
    localparam int unsigned TO   = 16;
    localparam logic [7:0]  POLY = 8'h8C;

    typedef struct {
        int unsigned gap;
        bit          last;
        logic [7:0]  b;
    } item_t;

    typedef struct {
        bit          err;
        bit          id;
        logic [7:0]  crc_a;
        logic [7:0]  crc_b;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  v = '0;
    logic [1:0]  l = '0;
    logic [15:0] d = '0;

    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned n_err = 0;

    item_t       q[2][$];
    logic [7:0]  cur[2][$];
    int unsigned idle[2];
    bit          meas[2];
    int unsigned lowcnt[2];
    exp_t        expq[$];
    bit          obs_ids[$];

    crc8_frame_arbiter_if bus_a ();
    crc8_frame_arbiter_if bus_b ();

    assign bus_a.in_valid = v;
    assign bus_a.in_data  = d;
    assign bus_a.in_last  = l;
    assign bus_b.in_valid = v;
    assign bus_b.in_data  = d;
    assign bus_b.in_last  = l;

    crc8_frame_arbiter #(.INIT(8'hFF), .POLY(8'h8C), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    crc8_frame_arbiter #(.INIT(8'h00), .POLY(8'h8C), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, int unsigned act, int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc_model(logic [7:0] init, logic [7:0] bytes[$]);
        logic [7:0] c;
        c = init;
        foreach (bytes[i]) begin
            c = c ^ bytes[i];
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    task automatic enq_frame(int r, logic [7:0] bytes[$], int unsigned gap0, int unsigned maxgap);
        foreach (bytes[i]) begin
            item_t it;
            it.gap  = (i == 0) ? gap0 : $urandom_range(0, maxgap);
            it.last = (i == bytes.size() - 1);
            it.b    = bytes[i];
            q[r].push_back(it);
        end
    endtask

    task automatic step();
        logic [1:0] rdy;
        logic [1:0] acc;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (q[r].size() != 0 && q[r][0].gap == 0) begin
                v[r]          = 1'b1;
                d[8*r +: 8]   = q[r][0].b;
                l[r]          = q[r][0].last;
            end else begin
                v[r]          = 1'b0;
                d[8*r +: 8]   = 8'($urandom);
                l[r]          = 1'($urandom);
                if (q[r].size() != 0) begin
                    item_t it;
                    it = q[r][0];
                    it.gap = it.gap - 1;
                    q[r][0] = it;
                end
            end
        end
        #1;
        rdy = bus_a.in_ready;
        acc = v & rdy;
        check("ready_onehot", ($countones(rdy) <= 1), 1);
        for (int r = 0; r < 2; r++) begin
            if (meas[r]) begin
                if (!rdy[r]) lowcnt[r]++;
                else begin
                    check("ready_gap", lowcnt[r], 8);
                    meas[r] = 1'b0;
                end
            end
            if (rdy[r] && !v[r] && cur[r].size() != 0) begin
                idle[r]++;
                if (idle[r] == TO) begin
                    exp_t e;
                    e.err = 1'b1; e.id = 1'(r); e.crc_a = '0; e.crc_b = '0; e.cyc = cyc + 1;
                    expq.push_back(e);
                    cur[r].delete();
                    idle[r] = 0;
                end
            end
            if (acc[r] && q[r][0].last) begin
                exp_t e;
                logic [7:0] fr[$];
                fr = cur[r];
                fr.push_back(q[r][0].b);
                e.err = 1'b0; e.id = 1'(r);
                e.crc_a = crc_model(8'hFF, fr);
                e.crc_b = crc_model(8'h00, fr);
                e.cyc = cyc + 10;
                expq.push_back(e);
            end
        end
        @(posedge clk);
        for (int r = 0; r < 2; r++) begin
            if (acc[r]) begin
                idle[r] = 0;
                if (q[r][0].last) cur[r].delete();
                else begin
                    cur[r].push_back(q[r][0].b);
                    meas[r]   = 1'b1;
                    lowcnt[r] = 0;
                end
                void'(q[r].pop_front());
            end
        end
    endtask

    task automatic run_until_idle(int unsigned bound);
        int unsigned n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0 || expq.size() != 0 || bus_a.busy) && n < bound) begin
            step();
            n++;
        end
        check("drain_in_bound", (n < bound), 1);
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_ready"}, bus_a.in_ready, 0);
        check({tag, "_busy"}, bus_a.busy, 0);
        check({tag, "_valid"}, bus_a.crc_valid, 0);
        check({tag, "_err"}, bus_a.frame_err, 0);
        check({tag, "_crc"}, bus_a.crc_out, 0);
        check({tag, "_id"}, bus_a.crc_id, 0);
    endtask

    // Monitor: pops the scoreboard whenever either instance strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && (bus_a.crc_valid || bus_a.frame_err || bus_b.crc_valid || bus_b.frame_err)) begin
                if (expq.size() == 0) begin
                    check("unexpected_strobe_a", {bus_a.crc_valid, bus_a.frame_err}, 0);
                    check("unexpected_strobe_b", {bus_b.crc_valid, bus_b.frame_err}, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("kind_a", {bus_a.crc_valid, bus_a.frame_err}, e.err ? 1 : 2);
                    check("kind_b", {bus_b.crc_valid, bus_b.frame_err}, e.err ? 1 : 2);
                    check("when", cyc, e.cyc);
                    if (!e.err) begin
                        check("crc_a", bus_a.crc_out, e.crc_a);
                        check("crc_b", bus_b.crc_out, e.crc_b);
                        check("id_a", bus_a.crc_id, e.id);
                        check("id_b", bus_b.crc_id, e.id);
                    end
                end
                if (bus_a.crc_valid) obs_ids.push_back(bus_a.crc_id);
                if (bus_a.frame_err) n_err++;
            end
        end
    end

    initial begin
        logic [7:0] f[$];
        int unsigned errs0;
        int unsigned n;

        repeat (3) @(negedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single byte 00 -> 35
        f = '{8'h00};
        enq_frame(0, f, 0, 0);
        run_until_idle(200);
        check("t1_crc", bus_a.crc_out, 8'h35);
        check("t1_id", bus_a.crc_id, 0);

        // Two bytes 00,00 -> 81
        f = '{8'h00, 8'h00};
        enq_frame(0, f, 0, 0);
        run_until_idle(200);
        check("t2_crc", bus_a.crc_out, 8'h81);

        // "123456789" from requester 1 on the INIT=00 instance -> A1
        f.delete();
        for (int i = 0; i < 9; i++) f.push_back(8'(8'h31 + i));
        enq_frame(1, f, 0, 0);
        run_until_idle(400);
        check("t3_crc", bus_b.crc_out, 8'hA1);
        check("t3_id", bus_b.crc_id, 1);

        // Contention: grant order 0,1,0
        obs_ids.delete();
        f = '{8'hAB}; enq_frame(0, f, 0, 0);
        f = '{8'hCD}; enq_frame(0, f, 0, 0);
        f = '{8'h12}; enq_frame(1, f, 0, 0);
        run_until_idle(400);
        check("t4_count", obs_ids.size(), 3);
        if (obs_ids.size() == 3) begin
            check("t4_g0", obs_ids[0], 0);
            check("t4_g1", obs_ids[1], 1);
            check("t4_g2", obs_ids[2], 0);
        end

        // Timeout abort, then a clean 00 frame
        errs0 = n_err;
        q[0].push_back('{gap: 0, last: 1'b0, b: 8'h5A});
        q[0].push_back('{gap: 30, last: 1'b1, b: 8'h00});
        run_until_idle(400);
        check("t5_errs", n_err - errs0, 1);
        check("t5_crc", bus_a.crc_out, 8'h35);

        // Reset in the middle of SHIFT
        f = '{8'h77};
        enq_frame(0, f, 0, 0);
        n = 0;
        while (q[0].size() != 0 && n < 50) begin step(); n++; end
        check("t6_accept_in_bound", (n < 50), 1);
        repeat (3) step();
        @(negedge clk);
        reset_n = 1'b0;
        v = '0;
        #1;
        check_cleared("midreset");
        expq.delete();
        for (int r = 0; r < 2; r++) begin
            q[r].delete(); cur[r].delete(); idle[r] = 0; meas[r] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        obs_ids.delete();
        f = '{8'h00}; enq_frame(0, f, 0, 0);
        f = '{8'h00}; enq_frame(1, f, 0, 0);
        run_until_idle(400);
        check("t6_count", obs_ids.size(), 2);
        if (obs_ids.size() == 2) begin
            check("t6_first", obs_ids[0], 0);
            check("t6_second", obs_ids[1], 1);
        end
        check("t6_crc", bus_a.crc_out, 8'h35);

        // Randomised traffic on both requesters
        for (int k = 0; k < 40; k++) begin
            int unsigned len;
            f.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < int'(len); i++) f.push_back(8'($urandom));
            enq_frame(int'($urandom_range(0, 1)), f, $urandom_range(0, 6), 3);
        end
        run_until_idle(30000);
        check("scoreboard_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
